// File: rtl/uart_receiver.sv
// UART receiver: start, 8 data bits (MSB first), even parity, stop; reports parity and framing errors.
// Define UART_RX_SYNC_EN to pass rx_in through a 2-flop synchronizer (adds 2 cycles of latency).
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rx_enable,
  input  logic       rx_in,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       busy
);

  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  // START counts from the detect edge, so the mid-start sample is one count early
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'((HALF > 0) ? (HALF - 1) : 0);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_WAIT_HIGH = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_PARITY    = 3'd4,
    S_STOP      = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shreg;
  logic             r_par_bit;
  logic             w_rx_s;
  logic             w_start_tick;
  logic             w_bit_tick;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_busy_set;
  logic             w_busy_clr;
  logic             w_shift;
  logic             w_par_cap;
  logic             w_done;

`ifdef UART_RX_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (rx_enable) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;
`else
  assign w_rx_s = rx_in;
`endif

  assign w_start_tick = (r_clk_cnt == START_LAST);
  assign w_bit_tick   = (r_clk_cnt == BIT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rx_enable) r_state <= S_WAIT_HIGH;
    else           r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_WAIT_HIGH: if (w_rx_s) w_state_next = S_IDLE;
      S_IDLE:      if (!w_rx_s) w_state_next = (HALF == 0) ? S_DATA : S_START;
      S_START:     if (w_start_tick) w_state_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (w_bit_tick && (r_bit_cnt == 3'd7)) w_state_next = S_PARITY;
      S_PARITY:    if (w_bit_tick) w_state_next = S_STOP;
      S_STOP:      if (w_bit_tick) w_state_next = w_rx_s ? S_IDLE : S_WAIT_HIGH;
      default:     w_state_next = S_WAIT_HIGH;
    endcase
  end

  // Datapath strobes decoded from state and counters
  always_comb begin
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_busy_set = 1'b0;
    w_busy_clr = 1'b0;
    w_shift    = 1'b0;
    w_par_cap  = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_cnt_clr  = 1'b1;
          w_busy_set = 1'b1;
        end
      end
      S_START: begin
        if (w_start_tick) begin
          w_cnt_clr  = 1'b1;
          w_busy_clr = w_rx_s;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DATA, S_PARITY, S_STOP: begin
        if (w_bit_tick) begin
          w_cnt_clr = 1'b1;
          w_shift   = (r_state == S_DATA);
          w_par_cap = (r_state == S_PARITY);
          w_done    = (r_state == S_STOP);
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rx_enable) begin
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_par_bit   <= 1'b0;
      rx_data_out <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (w_cnt_clr)      r_clk_cnt <= '0;
      else if (w_cnt_inc) r_clk_cnt <= r_clk_cnt + CNT_W'(1);
      if (w_busy_set) begin
        busy      <= 1'b1;
        r_bit_cnt <= '0;
      end
      if (w_busy_clr) busy <= 1'b0;
      if (w_shift) begin
        r_shreg   <= {r_shreg[6:0], w_rx_s};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_par_cap) r_par_bit <= w_rx_s;
      if (w_done) begin
        rx_data_out <= r_shreg;
        rx_valid    <= 1'b1;
        parity_err  <= (r_par_bit != (^r_shreg));
        framing_err <= ~w_rx_s;
        busy        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: one instance at 1 clk/bit, one at 16 clks/bit.
`timescale 1ns/1ps
module tb_uart_receiver;

  typedef struct packed {
    logic        which;
    logic [31:0] stamp;
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
  } ev_t;

  logic       clk       = 1'b0;
  logic       rx_enable = 1'b1;
  logic       rx1       = 1'b1;
  logic       rx16      = 1'b1;
  logic [7:0] d1, d16;
  logic       v1, v16, pe1, pe16, fe1, fe16, b1, b16;

  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  ev_t  obs[$];
  ev_t  expq[$];

  uart_receiver #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rx_enable(rx_enable), .rx_in(rx1), .rx_data_out(d1),
    .rx_valid(v1), .parity_err(pe1), .framing_err(fe1), .busy(b1)
  );

  uart_receiver #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rx_enable(rx_enable), .rx_in(rx16), .rx_data_out(d16),
    .rx_valid(v16), .parity_err(pe16), .framing_err(fe16), .busy(b16)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge N, cyc == N
  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle in which rx_valid is high
  always @(negedge clk) begin
    ev_t e;
    if (v1 === 1'b1) begin
      e.which = 1'b0; e.stamp = 32'(cyc); e.data = d1; e.perr = pe1; e.ferr = fe1;
      obs.push_back(e);
    end
    if (v16 === 1'b1) begin
      e.which = 1'b1; e.stamp = 32'(cyc); e.data = d16; e.perr = pe16; e.ferr = fe16;
      obs.push_back(e);
    end
  end

  function automatic string fmt(input ev_t e);
    return $sformatf("dut%0d t=%0d data=%02h perr=%b ferr=%b",
                     e.which ? 16 : 1, e.stamp, e.data, e.perr, e.ferr);
  endfunction

  // Drive a line level for n rising edges, leaving time at posedge+1
  task automatic hold(input bit sel16, input logic v, input int n);
    if (sel16) rx16 = v;
    else       rx1  = v;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Send one frame and queue the reference event: valid rises on edge t0+HALF+10*CPB
  task automatic send_frame(input bit sel16, input logic [7:0] d,
                            input logic par_bit, input logic stop_bit);
    int  cpb;
    int  t0;
    ev_t e;
    cpb = sel16 ? 16 : 1;
    t0  = cyc + 1;
    e.which = sel16;
    e.stamp = 32'(t0 + (cpb - 1) / 2 + 10 * cpb);
    e.data  = d;
    e.perr  = (par_bit != (^d));
    e.ferr  = ~stop_bit;
    expq.push_back(e);
    hold(sel16, 1'b0, cpb);
    for (int i = 7; i >= 0; i--) hold(sel16, d[i], cpb);
    hold(sel16, par_bit, cpb);
    hold(sel16, stop_bit, cpb);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({d1, v1, pe1, fe1, b1} !== 12'h000) begin
      failures++;
      $display("FAIL reset_dut1: got %03h expected 000", {d1, v1, pe1, fe1, b1});
    end
    checks++;
    if ({d16, v16, pe16, fe16, b16} !== 12'h000) begin
      failures++;
      $display("FAIL reset_dut16: got %03h expected 000", {d16, v16, pe16, fe16, b16});
    end
    rx_enable = 1'b0;
    hold(1'b0, 1'b1, 2);
  endtask

  task automatic test_a5();
    obs.delete(); expq.delete();
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    hold(1'b0, 1'b1, 6);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL a5_count: got %0d frames expected %0d", obs.size(), expq.size());
    end
    foreach (expq[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL a5_frame: got %s expected %s", fmt(obs[i]), fmt(expq[i]));
      end
    end
    checks++;
    if ({d1, v1} !== {8'hA5, 1'b0}) begin
      failures++;
      $display("FAIL a5_hold: got data=%02h valid=%b expected data=a5 valid=0", d1, v1);
    end
  endtask

  task automatic test_parity();
    obs.delete(); expq.delete();
    send_frame(1'b0, 8'h3C, 1'b1, 1'b1);
    hold(1'b0, 1'b1, 6);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL parity_count: got %0d frames expected %0d", obs.size(), expq.size());
    end
    foreach (expq[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL parity_frame: got %s expected %s", fmt(obs[i]), fmt(expq[i]));
      end
    end
    checks++;
    if (pe1 !== 1'b1) begin
      failures++;
      $display("FAIL parity_held: got parity_err=%b expected 1", pe1);
    end
  endtask

  task automatic test_framing();
    obs.delete(); expq.delete();
    send_frame(1'b0, 8'h81, 1'b0, 1'b0);
    hold(1'b0, 1'b0, 3);
    checks++;
    if (b1 !== 1'b0) begin
      failures++;
      $display("FAIL framing_busy_low_line: got busy=%b expected 0", b1);
    end
    hold(1'b0, 1'b1, 2);
    send_frame(1'b0, 8'h55, 1'b0, 1'b1);
    hold(1'b0, 1'b1, 6);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL framing_count: got %0d frames expected %0d", obs.size(), expq.size());
    end
    foreach (expq[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL framing_frame%0d: got %s expected %s", i, fmt(obs[i]), fmt(expq[i]));
      end
    end
  endtask

  task automatic test_glitch16();
    obs.delete(); expq.delete();
    hold(1'b1, 1'b0, 2);
    checks++;
    if (b16 !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_set: got busy=%b expected 1", b16);
    end
    hold(1'b1, 1'b1, 20);
    checks++;
    if (b16 !== 1'b0 || obs.size() != 0) begin
      failures++;
      $display("FAIL glitch_false_start: got busy=%b frames=%0d expected busy=0 frames=0", b16, obs.size());
    end
    send_frame(1'b1, 8'hF0, 1'b0, 1'b1);
    hold(1'b1, 1'b1, 24);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL glitch_count: got %0d frames expected %0d", obs.size(), expq.size());
    end
    foreach (expq[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL glitch_frame: got %s expected %s", fmt(obs[i]), fmt(expq[i]));
      end
    end
  endtask

  task automatic test_abort();
    obs.delete(); expq.delete();
    hold(1'b0, 1'b0, 1);
    hold(1'b0, 1'b1, 4);
    checks++;
    if (b1 !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy_mid: got busy=%b expected 1", b1);
    end
    rx_enable = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({d1, v1, pe1, fe1, b1} !== 12'h000) begin
      failures++;
      $display("FAIL abort_reset: got %03h expected 000", {d1, v1, pe1, fe1, b1});
    end
    rx_enable = 1'b0;
    hold(1'b0, 1'b1, 14);
    checks++;
    if (obs.size() != 0) begin
      failures++;
      $display("FAIL abort_discard: got %0d frames expected 0", obs.size());
    end
    send_frame(1'b0, 8'h12, 1'b0, 1'b1);
    hold(1'b0, 1'b1, 6);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL abort_count: got %0d frames expected %0d", obs.size(), expq.size());
    end
    foreach (expq[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL abort_frame: got %s expected %s", fmt(obs[i]), fmt(expq[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    obs.delete(); expq.delete();
    send_frame(1'b0, 8'h01, 1'b1, 1'b1);
    send_frame(1'b0, 8'hFE, 1'b1, 1'b1);
    hold(1'b0, 1'b1, 6);
    checks++;
    if (obs.size() != 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d frames expected 2", obs.size());
    end else begin
      checks++;
      if (obs[1].stamp - obs[0].stamp != 32'd11) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d cycles expected 11", obs[1].stamp - obs[0].stamp);
      end
    end
    foreach (expq[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL b2b_frame%0d: got %s expected %s", i, fmt(obs[i]), fmt(expq[i]));
      end
    end
  endtask

  task automatic test_random(input bit sel16, input int n);
    logic [7:0] d;
    logic       flip;
    logic       stop;
    int         cpb;
    cpb = sel16 ? 16 : 1;
    obs.delete(); expq.delete();
    for (int k = 0; k < n; k++) begin
      d    = 8'($urandom);
      flip = ($urandom_range(3) == 0);
      stop = ($urandom_range(5) != 0);
      send_frame(sel16, d, (^d) ^ flip, stop);
      if (!stop) begin
        hold(sel16, 1'b0, $urandom_range(3));
        hold(sel16, 1'b1, 1);
      end else begin
        hold(sel16, 1'b1, $urandom_range(3));
      end
    end
    hold(sel16, 1'b1, 12 * cpb + 4);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL random%0d_count: got %0d frames expected %0d", cpb, obs.size(), expq.size());
    end
    foreach (expq[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL random%0d_frame%0d: got %s expected %s", cpb, i, fmt(obs[i]), fmt(expq[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_parity();
    test_framing();
    test_glitch16();
    test_abort();
    test_back_to_back();
    test_random(1'b0, 30);
    test_random(1'b1, 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the downstream stage of the UART transmitter on the same link.
- Frame format, LSB-of-time first on the wire:
  - start bit 0
  - 8 data bits, MSB first
  - even-parity bit (parity = XOR of the data)
  - stop bit 1
- Recovers the byte, checks parity and stop, and presents the byte with a one-cycle valid pulse to the protocol-controller core.
- Default timing is one bit per clk, matching the transmitter; oversampling is available via a parameter.

Parameters:
- CLKS_PER_BIT, 1, clocks per serial bit; legal range 1..1024. Bit counter width is $clog2(CLKS_PER_BIT)+1.
- HALF (localparam), (CLKS_PER_BIT-1)/2, integer division; offset from detected start edge to the mid-bit sample.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rx_enable  input  1  synchronous active-high reset (same role as tx_enable on the transmitter).
- rx_in  input  1  serial line; idles high.
- rx_data_out  output  8  last received byte; holds until the next frame completes.
- rx_valid  output  1  one-cycle pulse: frame complete, rx_data_out updated.
- parity_err  output  1  valid with rx_valid: received parity != ^rx_data_out.
- framing_err  output  1  valid with rx_valid: stop bit sampled 0.
- busy  output  1  high while a frame is being received.

Behaviour:
- Line signal: rx_s is rx_in directly, or synchronized when RX_SYNC_EN is defined (see Optional Feature).
- Reset (rx_enable=1 at posedge):
  - rx_data_out=0, rx_valid=0, parity_err=0, framing_err=0, busy=0.
  - Counters 0; state=WAIT_HIGH. Dominates all other activity, including mid-frame: the partial frame is discarded and no rx_valid is produced.
- States:
  - WAIT_HIGH: go to IDLE on the first cycle rx_s==1. Prevents a line held low from being taken as a start.
  - IDLE: rx_valid=0. If rx_s==0, this is cycle t0:
    - busy<=1, clk_cnt<=0.
    - If HALF==0, the start is validated now: go to DATA with bit_cnt=0, clk_cnt=0.
    - Otherwise go to START.
  - START:
    - clk_cnt increments each cycle; at clk_cnt==HALF, sample rx_s.
    - Sample 1 means false start: busy<=0, go to IDLE, no flags, no rx_valid.
    - Sample 0: go to DATA, clk_cnt=0.
  - DATA:
    - Sample when clk_cnt==CLKS_PER_BIT-1, then clk_cnt<=0; else increment.
    - Data samples fall at t0+HALF+k*CLKS_PER_BIT, k=1..8.
    - Each sample shifts in at the LSB (shreg<={shreg[6:0],rx_s}), so the first data bit ends up in bit 7.
    - After the 8th sample, go to PARITY.
  - PARITY: same timing; capture par_bit at k=9; go to STOP.
  - STOP: at k=10 sample the stop bit. On that same edge:
    - rx_data_out<=shreg, rx_valid<=1, parity_err<=(par_bit != ^shreg), framing_err<=(stop==0), busy<=0.
    - Next state IDLE if stop==1, WAIT_HIGH if stop==0.
- Timing:
  - rx_valid is high exactly one cycle, in cycle t0+HALF+10*CLKS_PER_BIT+1, then auto-clears.
  - Error flags are held until the next rx_valid or reset.
  - Data is delivered even when an error flag is set.
- Back-to-back frames: a new start may be detected in the cycle rx_valid is high (IDLE already entered). No dead cycle is required beyond the stop bit.
- No flow control: the consumer must take the byte on rx_valid; the next frame overwrites it.

Optional Feature:
- Macro UART_RX_SYNC_EN.
- Defined: rx_in passes through a 2-flop synchronizer; both flops reset to 1. rx_s = second flop, so all sample points shift 2 cycles later relative to rx_in.
- Undefined: rx_s = rx_in, zero added latency. Legal only when rx_in comes from same-clock logic.

Test Plan:
- CLKS_PER_BIT=1, frame for 0xA5 (line 0,1,0,1,0,0,1,0,1,0,1) -> rx_data_out=0xA5, parity_err=0, framing_err=0, rx_valid one cycle at t0+11.
- 0x3C sent with parity bit forced 1 -> rx_data_out=0x3C, rx_valid=1, parity_err=1, framing_err=0.
- 0x81 with stop bit 0, line held low 3 cycles then high -> framing_err=1; no new frame until the line returns high; next frame 0x55 received with framing_err=0.
- CLKS_PER_BIT=16, 2-cycle low glitch on idle line -> false start at HALF=7, busy drops, no rx_valid. Then a full 0xF0 frame -> 0xF0 with valid at t0+168.
- rx_enable pulsed after 4 data bits of 0xFF -> all outputs 0, no rx_valid. Following frame 0x12 received correctly.
- Two frames 0x01, 0xFE back-to-back with no idle gap -> two rx_valid pulses 11 cycles apart, both error-free.
